// File: rtl/hxmpp_pkg.sv
// hxmpp_pkg: HCM row/word widths, readout FSM states and HCM word decode.
// Shared by the hcm_readout_ctrl slice.
package hxmpp_pkg;

  localparam int ROWINDEXBITS_HCM = 12;
  localparam int NCOLS_HCM        = 19;
  localparam int MAXHITNBITS      = 3;
  localparam int HIMADDRBITS      = NCOLS_HCM - MAXHITNBITS;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } ro_state_t;

  typedef struct packed {
    logic [HIMADDRBITS-1:0] him_addr;
    logic [MAXHITNBITS-1:0] nhits;
  } hcm_ent_t;

  function automatic hcm_ent_t hcm_decode(
    input logic [NCOLS_HCM-1:0] w
  );
    hcm_ent_t e;
    e.him_addr = w[NCOLS_HCM-1:MAXHITNBITS];
    e.nhits    = w[MAXHITNBITS-1:0];
    return e;
  endfunction

endpackage

// File: rtl/hcm_ro_fifo.sv
// hcm_ro_fifo: synchronous first-word-fall-through FIFO with fill count.
// DEPTH must be a power of 2 and at least 2.
module hcm_ro_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_empty,
  output logic             o_full,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_wr;
  logic             w_rd;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_count = r_count;
  assign w_rd    = i_pop && !o_empty;
  // A pop frees the head slot, so a push while full is fine alongside it
  assign w_wr    = i_push && (!o_full || w_rd);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      if (w_wr && !w_rd)
        r_count <= r_count + 1'b1;
      else if (w_rd && !w_wr)
        r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= i_din;
  end

  assign o_dout = o_empty ? '0 : r_mem[r_rptr];

  a_no_overflow: assert property (
    @(posedge clk) disable iff (reset)
    !(i_push && o_full && !w_rd)
  );

endmodule

// File: rtl/hcm_readout_ctrl.sv
// hcm_readout_ctrl: credit-paced HCM read initiator with decoded FWFT output.
// Define HCM_RO_ORDERCHK_EN to build the response order checker driving err.
module hcm_readout_ctrl
  import hxmpp_pkg::*;
#(
  parameter int ROWBITS      = ROWINDEXBITS_HCM,
  parameter int NCOLS        = NCOLS_HCM,
  parameter int HITBITS      = MAXHITNBITS,
  parameter int HIMBITS      = NCOLS - HITBITS,
  parameter int FIFO_DEPTH   = 8,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               req_valid,
  input  logic [ROWBITS-1:0] req_row,
  input  logic               req_last,
  output logic               req_ready,
  input  logic               hcm_read_ready,
  output logic               hcm_read_en,
  output logic [ROWBITS-1:0] hcm_read_row,
  input  logic               rsp_valid,
  input  logic [ROWBITS-1:0] rsp_row,
  input  logic [NCOLS-1:0]   rsp_data,
  output logic               out_valid,
  output logic [ROWBITS-1:0] out_row,
  output logic [HIMBITS-1:0] out_him_addr,
  output logic [HITBITS-1:0] out_nhits,
  input  logic               out_ready,
  output logic               busy,
  output logic               done,
  output logic [15:0]        dropped_cnt,
  output logic               err
);

  localparam int IW = $clog2(MAX_INFLIGHT + 1);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int OW = ROWBITS + HIMBITS + HITBITS;

  ro_state_t           r_state;
  ro_state_t           w_next;
  logic [IW-1:0]       r_inflight;
  logic                r_rd_en;
  logic [ROWBITS-1:0]  r_rd_row;
  logic                r_busy;
  logic                r_done;
  logic [15:0]         r_dropped;

  logic                w_start;
  logic                w_acc;
  logic                w_rsp;
  logic                w_push;
  logic                w_pop;
  logic                w_fempty;
  logic                w_unused_ofull;
  logic [CW-1:0]       w_fcount;
  logic [OW-1:0]       w_fdout;
  logic [HIMBITS-1:0]  w_him;
  logic [HITBITS-1:0]  w_nhits;

  if (NCOLS == NCOLS_HCM && HITBITS == MAXHITNBITS &&
      HIMBITS == HIMADDRBITS) begin : g_pkg_dec
    hcm_ent_t w_ent;
    assign w_ent   = hcm_decode(rsp_data);
    assign w_him   = w_ent.him_addr;
    assign w_nhits = w_ent.nhits;
  end else begin : g_gen_dec
    assign w_him   = rsp_data[NCOLS-1:HITBITS];
    assign w_nhits = rsp_data[HITBITS-1:0];
  end

  // Credits cover both in-flight reads and buffered entries: no rsp stall
  assign req_ready = (r_state == RUN) && hcm_read_ready &&
                     (r_inflight < IW'(MAX_INFLIGHT)) &&
                     ((int'(w_fcount) + int'(r_inflight)) < FIFO_DEPTH);

  assign w_start = (r_state == IDLE) && start;
  assign w_acc   = req_valid && req_ready;
  assign w_rsp   = rsp_valid && (r_inflight != '0);
  assign w_push  = w_rsp && (w_nhits != '0);
  assign w_pop   = out_valid && out_ready;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (w_acc && req_last) w_next = DRAIN;
      DRAIN:   if (r_inflight == '0 && w_fempty) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_inflight <= '0;
      r_rd_en    <= 1'b0;
      r_rd_row   <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_dropped  <= '0;
    end else begin
      r_state    <= w_next;
      r_inflight <= r_inflight + IW'(w_acc) - IW'(w_rsp);
      r_rd_en    <= w_acc;
      if (w_acc) r_rd_row <= req_row;
      r_busy     <= (r_state != IDLE);
      r_done     <= (r_state == DRAIN) && (w_next == IDLE);
      if (w_start)
        r_dropped <= '0;
      else if (w_rsp && w_nhits == '0 && r_dropped != 16'hFFFF)
        r_dropped <= r_dropped + 1'b1;
    end
  end

  hcm_ro_fifo #(
    .WIDTH (OW),
    .DEPTH (FIFO_DEPTH)
  ) u_obuf (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_din   ({rsp_row, w_him, w_nhits}),
    .i_pop   (w_pop),
    .o_dout  (w_fdout),
    .o_empty (w_fempty),
    .o_full  (w_unused_ofull),
    .o_count (w_fcount)
  );

  assign out_valid = !w_fempty;
  assign {out_row, out_him_addr, out_nhits} = w_fdout;

  assign hcm_read_en  = r_rd_en;
  assign hcm_read_row = r_rd_row;
  assign busy         = r_busy;
  assign done         = r_done;
  assign dropped_cnt  = r_dropped;

`ifdef HCM_RO_ORDERCHK_EN
  logic [ROWBITS-1:0]            w_exp_row;
  logic                          w_unused_xempty;
  logic                          w_unused_xfull;
  logic [$clog2(MAX_INFLIGHT):0] w_unused_xcnt;
  logic                          r_err;

  hcm_ro_fifo #(
    .WIDTH (ROWBITS),
    .DEPTH (MAX_INFLIGHT)
  ) u_exp (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_acc),
    .i_din   (req_row),
    .i_pop   (w_rsp),
    .o_dout  (w_exp_row),
    .o_empty (w_unused_xempty),
    .o_full  (w_unused_xfull),
    .o_count (w_unused_xcnt)
  );

  always_ff @(posedge clk) begin
    if (reset)
      r_err <= 1'b0;
    else if (w_start)
      r_err <= 1'b0;
    else if ((w_rsp && rsp_row != w_exp_row) ||
             (rsp_valid && r_inflight == '0))
      r_err <= 1'b1;
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_hcm_readout_ctrl.sv
// tb_hcm_readout_ctrl: directed bench with an HCM latency model.
// Works with and without HCM_RO_ORDERCHK_EN.
module tb_hcm_readout_ctrl;

  localparam int RB = 12;
  localparam int NC = 19;
  localparam int HB = 3;
  localparam int MB = 16;
`ifdef HCM_RO_ORDERCHK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          req_valid = 1'b0;
  logic [RB-1:0] req_row = '0;
  logic          req_last = 1'b0;
  logic          req_ready;
  logic          hcm_read_ready = 1'b1;
  logic          hcm_read_en;
  logic [RB-1:0] hcm_read_row;
  logic          rsp_valid;
  logic [RB-1:0] rsp_row;
  logic [NC-1:0] rsp_data;
  logic          out_valid;
  logic [RB-1:0] out_row;
  logic [MB-1:0] out_him_addr;
  logic [HB-1:0] out_nhits;
  logic          out_ready = 1'b1;
  logic          busy;
  logic          done;
  logic [15:0]   dropped_cnt;
  logic          err;

  always #5 clk = ~clk;

  hcm_readout_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .req_valid      (req_valid),
    .req_row        (req_row),
    .req_last       (req_last),
    .req_ready      (req_ready),
    .hcm_read_ready (hcm_read_ready),
    .hcm_read_en    (hcm_read_en),
    .hcm_read_row   (hcm_read_row),
    .rsp_valid      (rsp_valid),
    .rsp_row        (rsp_row),
    .rsp_data       (rsp_data),
    .out_valid      (out_valid),
    .out_row        (out_row),
    .out_him_addr   (out_him_addr),
    .out_nhits      (out_nhits),
    .out_ready      (out_ready),
    .busy           (busy),
    .done           (done),
    .dropped_cnt    (dropped_cnt),
    .err            (err)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // HCM model: row word table, fixed latency from hcm_read_en
  logic [NC-1:0] mem [0:4095];
  int            cyc = 0;
  int            lat = 2;
  bit            manual = 1'b0;
  logic          a_valid = 1'b0;
  logic [RB-1:0] a_row = '0;
  logic [NC-1:0] a_data = '0;
  logic          m_valid = 1'b0;
  logic [RB-1:0] m_row = '0;
  logic [NC-1:0] m_data = '0;
  int            due_q[$];
  logic [RB-1:0] row_q[$];

  assign rsp_valid = manual ? m_valid : a_valid;
  assign rsp_row   = manual ? m_row   : a_row;
  assign rsp_data  = manual ? m_data  : a_data;

  always @(posedge clk) begin
    #1;
    cyc++;
    a_valid = 1'b0;
    if (due_q.size() > 0 && due_q[0] <= cyc) begin
      a_valid = 1'b1;
      a_row   = row_q[0];
      a_data  = mem[row_q[0]];
      void'(due_q.pop_front());
      void'(row_q.pop_front());
    end
  end

  // Monitor: sampled on the falling edge
  int            n_acc = 0, n_pop = 0, n_drop = 0, n_rsp = 0;
  int            n_done = 0;
  int            outst, infl;
  int            outst_max = 0, infl_max = 0, viol = 0;
  int            rd_err = 0, rd_low = 0;
  int            first_acc = -1, last_acc = 0;
  int            exp_ov_cyc = -10, ov_err = 0, ov_seen = 0;
  logic          prev_acc = 1'b0;
  logic          prev_hrr = 1'b1;
  logic [RB-1:0] prev_row = '0;
  logic [RB+NC-1:0] got_q[$];

  always @(negedge clk) begin
    if (reset) begin
      due_q.delete();
      row_q.delete();
      n_acc = 0; n_pop = 0; n_drop = 0; n_rsp = 0;
      prev_acc = 1'b0;
      prev_hrr = 1'b1;
    end else begin
      outst = n_acc - n_pop - n_drop;
      infl  = n_acc - n_rsp;
      if (outst > outst_max) outst_max = outst;
      if (infl > infl_max) infl_max = infl;
      if (req_ready && (outst >= 8 || infl >= 4)) viol++;
      if (hcm_read_en !== prev_acc) rd_err++;
      if (prev_acc && hcm_read_row !== prev_row) rd_err++;
      if (hcm_read_en && !prev_hrr) rd_low++;
      if (cyc == exp_ov_cyc) begin
        ov_seen++;
        if (!out_valid) ov_err++;
      end
      if (hcm_read_en && !manual) begin
        due_q.push_back(cyc + lat);
        row_q.push_back(hcm_read_row);
      end
      if (req_valid && req_ready) begin
        n_acc++;
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
      end
      prev_acc = req_valid && req_ready;
      prev_row = req_row;
      prev_hrr = hcm_read_ready;
      if (rsp_valid && infl > 0) begin
        n_rsp++;
        if (rsp_data[HB-1:0] == '0) n_drop++;
        else if (!out_valid) exp_ov_cyc = cyc + 1;
      end
      if (out_valid && out_ready) begin
        got_q.push_back({out_row, out_him_addr, out_nhits});
        n_pop++;
      end
      if (done) n_done++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send(input int n, input int base);
    int t;
    for (int i = 0; i < n; i++) begin
      req_valid = 1'b1;
      req_row   = RB'(base + i);
      req_last  = (i == n - 1);
      t = 0;
      forever begin
        @(negedge clk);
        if (req_ready) break;
        t++;
        if (t > 300) break;
      end
      step();
      if (t > 300) begin
        chk("send_timeout", t, 0);
        break;
      end
    end
    req_valid = 1'b0;
    req_last  = 1'b0;
  endtask

  // Leaves the caller on the falling edge of the done cycle
  task automatic wait_done(input string tag);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!done && t < 500);
    chk({tag, "_done"}, done, 1);
  endtask

  task automatic chk_list(input string tag, input int base, input int n);
    logic [RB+NC-1:0] e;
    int k, nerr, nexp;
    k = 0; nerr = 0; nexp = 0;
    for (int i = 0; i < n; i++) begin
      if (mem[base + i][HB-1:0] != '0) begin
        e = {RB'(base + i), mem[base + i]};
        nexp++;
        if (k >= got_q.size() || got_q[k] !== e) nerr++;
        k++;
      end
    end
    chk({tag, "_count"}, got_q.size(), nexp);
    chk({tag, "_data"}, nerr, 0);
  endtask

  logic [RB+NC-1:0] g;

  initial begin
    for (int i = 0; i < 4096; i++)
      mem[i] = {16'(i * 5 + 3), 3'(i % 7 + 1)};
    mem[12'h005] = 19'h000A3;
    mem[12'h011] = 19'h000A0;

    repeat (3) step();
    @(negedge clk);
    chk("rst_ctl", {req_ready, hcm_read_en, out_valid, busy, done, err}, 0);
    chk("rst_rdrow", hcm_read_row, 0);
    chk("rst_out", {out_row, out_him_addr, out_nhits}, 0);
    chk("rst_drop", dropped_cnt, 0);
    step();
    reset = 1'b0;
    step();

    // single read: 0x0A3 -> addr 0x14, nhits 3
    got_q.delete();
    n_done = 0;
    do_start();
    send(1, 12'h005);
    wait_done("t1");
    chk("t1_busy_at_done", busy, 1);
    step();
    @(negedge clk);
    chk("t1_busy_after", busy, 0);
    chk("t1_done_pulse", done, 0);
    step();
    chk("t1_n", got_q.size(), 1);
    g = got_q[0];
    chk("t1_row", g[30:19], 12'h005);
    chk("t1_addr", g[18:3], 16'h0014);
    chk("t1_nhits", g[2:0], 3);
    chk("t1_ndone", n_done, 1);

    // zero-hit drop on the second of four rows
    got_q.delete();
    do_start();
    send(4, 12'h010);
    wait_done("t2");
    chk("t2_drop", dropped_cnt, 1);
    step();
    chk("t2_n", got_q.size(), 3);
    g = got_q[1];
    chk("t2_row1", g[30:19], 12'h012);
    chk_list("t2", 12'h010, 4);

    // backpressure: out_ready low, 20 requests, latency 3
    lat = 3;
    out_ready = 1'b0;
    outst_max = 0;
    viol = 0;
    got_q.delete();
    do_start();
    fork
      send(20, 12'h100);
      begin
        repeat (40) step();
        out_ready = 1'b1;
      end
    join
    wait_done("t3");
    chk("t3_drop_clr", dropped_cnt, 0);
    step();
    chk("t3_outst_max", outst_max, 8);
    chk("t3_credit_viol", viol, 0);
    chk_list("t3", 12'h100, 20);

    // hcm_read_ready low for 5 cycles mid-stream, latency 4
    lat = 4;
    infl_max = 0;
    rd_low = 0;
    viol = 0;
    got_q.delete();
    do_start();
    fork
      send(12, 12'h200);
      begin
        repeat (4) step();
        hcm_read_ready = 1'b0;
        repeat (5) step();
        hcm_read_ready = 1'b1;
      end
    join
    wait_done("t4");
    step();
    chk("t4_rd_while_low", rd_low, 0);
    chk("t4_infl_max", infl_max, 4);
    chk("t4_credit_viol", viol, 0);
    chk_list("t4", 12'h200, 12);

    // throughput: one accept per cycle
    lat = 2;
    first_acc = -1;
    got_q.delete();
    do_start();
    send(8, 12'h300);
    wait_done("t5");
    step();
    chk("t5_span", last_acc - first_acc, 7);
    chk_list("t5", 12'h300, 8);

    // order check: swapped responses
    manual = 1'b1;
    m_valid = 1'b0;
    do_start();
    send(2, 12'h020);
    m_valid = 1'b1;
    m_row = 12'h021;
    m_data = mem[12'h021];
    step();
    m_row = 12'h020;
    m_data = mem[12'h020];
    step();
    m_valid = 1'b0;
    wait_done("t6");
    chk("t6_err", err, EXP_ERR);
    step();
    repeat (3) step();
    @(negedge clk);
    chk("t6_err_hold", err, EXP_ERR);
    step();
    manual = 1'b0;
    do_start();
    @(negedge clk);
    chk("t6_err_clr", err, 0);
    step();
    send(1, 12'h022);
    wait_done("t6b");
    step();

    // reset in DRAIN with 3 reads in flight, then a stale response
    manual = 1'b1;
    m_valid = 1'b0;
    got_q.delete();
    do_start();
    send(3, 12'h040);
    step();
    @(negedge clk);
    chk("t7_busy_pre", busy, 1);
    step();
    reset = 1'b1;
    step();
    @(negedge clk);
    chk("t7_rst_ctl",
        {req_ready, hcm_read_en, out_valid, busy, done, err}, 0);
    chk("t7_rst_out", {out_row, out_him_addr, out_nhits}, 0);
    chk("t7_rst_drop", dropped_cnt, 0);
    step();
    reset = 1'b0;
    step();
    m_valid = 1'b1;
    m_row = 12'h040;
    m_data = mem[12'h040];
    step();
    m_valid = 1'b0;
    @(negedge clk);
    chk("t7_stale_ov", out_valid, 0);
    chk("t7_stale_err", err, EXP_ERR);
    step();
    repeat (3) step();
    chk("t7_stale_n", got_q.size(), 0);
    manual = 1'b0;

    chk("rd_strobe", rd_err, 0);
    chk("fwft_seen", ov_seen > 0, 1);
    chk("fwft_lat", ov_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

endmodule
